// File: rtl/param_pkg.sv
// Shared data-bus geometry for the CPU-side dbus ports.
package param_pkg;
   parameter int DBUS_AW   = 32;
   parameter int DBUS_DW   = 32;
   parameter int DBUS_ISEL = 4;
endpackage

// File: rtl/dbus_rr_arbiter.sv
// Round-robin share of one dbus slave among NUM_MASTERS masters; slave sees req 1 cycle after a master, ack passes through combinationally.
// One transaction outstanding; later requests wait through BUSY and the 1-cycle RELEASE; watchdog pulses err_o on a silent slave.
module dbus_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int DBUS_AW     = param_pkg::DBUS_AW,
   parameter int DBUS_DW     = param_pkg::DBUS_DW,
   parameter int DBUS_ISEL   = param_pkg::DBUS_ISEL,
   parameter int TIMEOUT     = 256
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_MASTERS-1:0]           req_m2dbiu_i,
   input  logic [NUM_MASTERS*DBUS_AW-1:0]   adr_m2dbiu_i,
   input  logic [NUM_MASTERS*DBUS_DW-1:0]   dat_m2dbiu_i,
   input  logic [NUM_MASTERS-1:0]           we_m2dbiu_i,
   input  logic [NUM_MASTERS*DBUS_ISEL-1:0] sel_m2dbiu_i,
   output logic [NUM_MASTERS-1:0]           ack_dbiu2m_o,
   output logic [DBUS_DW-1:0]               dat_dbiu2m_o,
   output logic                             req_m2dbiu_o,
   output logic [DBUS_AW-1:0]               adr_m2dbiu_o,
   output logic [DBUS_DW-1:0]               dat_m2dbiu_o,
   output logic                             we_m2dbiu_o,
   output logic [DBUS_ISEL-1:0]             sel_m2dbiu_o,
   input  logic                             ack_dbiu2m_i,
   input  logic [DBUS_DW-1:0]               dat_dbiu2m_i,
   output logic [$clog2(NUM_MASTERS)-1:0]   grant_o,
   output logic                             busy_o,
   output logic                             err_o
);
   localparam int GW = $clog2(NUM_MASTERS);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] TO_SAT  = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] pick;
   logic [GW-1:0] cand;
   logic          any_req;
   logic [CW-1:0] wd_cnt;

   function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
      return GW'(s);
   endfunction

   // Scan downward so the requester closest to rr_ptr is written last and wins.
   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      cand    = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         cand = wrap_add(rr_ptr, i);
         if (req_m2dbiu_i[cand]) begin
            any_req = 1'b1;
            pick    = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      req_m2dbiu_o = 1'b0;
      busy_o       = 1'b0;
      adr_m2dbiu_o = '0;
      dat_m2dbiu_o = '0;
      we_m2dbiu_o  = 1'b0;
      sel_m2dbiu_o = '0;
      ack_dbiu2m_o = '0;
      case (state)
         IDLE: if (any_req) state_nxt = BUSY;
         BUSY: begin
            req_m2dbiu_o = 1'b1;
            busy_o       = 1'b1;
            adr_m2dbiu_o = adr_m2dbiu_i[grant_o*DBUS_AW +: DBUS_AW];
            dat_m2dbiu_o = dat_m2dbiu_i[grant_o*DBUS_DW +: DBUS_DW];
            we_m2dbiu_o  = we_m2dbiu_i[grant_o];
            sel_m2dbiu_o = sel_m2dbiu_i[grant_o*DBUS_ISEL +: DBUS_ISEL];
            if (ack_dbiu2m_i) begin
               ack_dbiu2m_o[grant_o] = 1'b1;
               state_nxt             = RELEASE;
            end
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign dat_dbiu2m_o = dat_dbiu2m_i;

   // Counter saturates at TIMEOUT, so the TO_LAST match fires err_o once per transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr  <= '0;
         grant_o <= '0;
         wd_cnt  <= '0;
         err_o   <= 1'b0;
      end else begin
         err_o <= 1'b0;
         case (state)
            IDLE: if (any_req) begin
               grant_o <= pick;
               wd_cnt  <= '0;
            end
            BUSY: if (ack_dbiu2m_i) begin
               rr_ptr <= wrap_add(grant_o, 1);
            end else begin
               if (wd_cnt != TO_SAT) wd_cnt <= wd_cnt + 1'b1;
               if ((TIMEOUT > 0) && (wd_cnt == TO_LAST)) err_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
